// File: rtl/tiny_soc_pkg.sv
// Shared definitions for the tiny accumulator SoC: opcodes, program-memory
// FSM states and the built-in default program image.
package tiny_soc_pkg;

  localparam int unsigned OPC_W = 4;

  localparam logic [OPC_W-1:0] OP_NOP  = 4'h0;
  localparam logic [OPC_W-1:0] OP_LDI  = 4'h1;
  localparam logic [OPC_W-1:0] OP_ADDI = 4'h2;
  localparam logic [OPC_W-1:0] OP_SUBI = 4'h3;
  localparam logic [OPC_W-1:0] OP_JZ   = 4'h5;
  localparam logic [OPC_W-1:0] OP_OUT  = 4'h6;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_LOAD = 2'd2
  } state_t;

  // Default program: LDI 5; ADDI 1; SUBI 1; JZ 3; OUT 8; NOP. Zero elsewhere.
  function automatic logic [7:0] boot_word(input int unsigned addr);
    logic [7:0] word;
    word = 8'h00;
    case (addr)
      0:       word = {OP_LDI,  4'h5};
      1:       word = {OP_ADDI, 4'h1};
      2:       word = {OP_SUBI, 4'h1};
      3:       word = {OP_JZ,   4'h3};
      4:       word = {OP_OUT,  4'h8};
      5:       word = {OP_NOP,  4'h0};
      default: word = 8'h00;
    endcase
    return word;
  endfunction

endpackage

// File: rtl/tiny_boot_image.sv
// Combinational lookup of the default program image, resized to DATA_W
// (zero-extended or truncated to the low bits).
module tiny_boot_image
  import tiny_soc_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data_c
);

  always_comb data_c = DATA_W'(boot_word(32'(addr)));

endmodule

// File: rtl/tiny_prog_mem.sv
// Loadable program memory: boot copy of the default image, registered
// fetch port, byte-stream loader. Define TINY_PROG_MEM_CSUM_EN to require a
// trailing checksum word on every load.
module tiny_prog_mem
  import tiny_soc_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_valid,
  input  logic              ld_start,
  input  logic [ADDR_W:0]   ld_len,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              ld_done,
  output logic              ld_err,
  output logic              busy
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  eff_len;
  logic [DATA_W-1:0] fetch_data_d;
  logic              fetch_valid_d, ld_ready_d, ld_done_d, ld_err_d, busy_d;
  logic              we;
  logic [IDX_W-1:0]  waddr;
  logic [DATA_W-1:0] wdata;
  logic [ADDR_W-1:0] boot_addr;
  logic [DATA_W-1:0] boot_data_c;
`ifdef TINY_PROG_MEM_CSUM_EN
  logic [DATA_W-1:0] sum_q, sum_d;
`endif

  assign boot_addr = ADDR_W'(cnt_q);

  tiny_boot_image #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_boot_image (
    .addr   (boot_addr),
    .data_c (boot_data_c)
  );

  // Single write port, shared by the boot copy and the loader.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_BOOT;
      cnt_q       <= '0;
      len_q       <= '0;
      fetch_data  <= '0;
      fetch_valid <= 1'b0;
      ld_ready    <= 1'b0;
      ld_done     <= 1'b0;
      ld_err      <= 1'b0;
      busy        <= 1'b1;
`ifdef TINY_PROG_MEM_CSUM_EN
      sum_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      fetch_data  <= fetch_data_d;
      fetch_valid <= fetch_valid_d;
      ld_ready    <= ld_ready_d;
      ld_done     <= ld_done_d;
      ld_err      <= ld_err_d;
      busy        <= busy_d;
`ifdef TINY_PROG_MEM_CSUM_EN
      sum_q       <= sum_d;
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    len_d         = len_q;
    fetch_data_d  = fetch_data;
    fetch_valid_d = 1'b0;
    ld_err_d      = ld_err;
    we            = 1'b0;
    waddr         = IDX_W'(cnt_q);
    wdata         = boot_data_c;
    eff_len       = (ld_len == '0) ? DEPTH_C : ld_len;
`ifdef TINY_PROG_MEM_CSUM_EN
    sum_d         = sum_q;
`endif

    case (state_q)
      ST_BOOT: begin
        we = 1'b1;
        if (cnt_q == LAST_C) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RUN: begin
        if (fetch_en) begin
          fetch_valid_d = 1'b1;
          fetch_data_d  = (CNT_W'(fetch_addr) < DEPTH_C) ? mem[IDX_W'(fetch_addr)] : '0;
        end
        if (ld_start) begin
          if (eff_len > DEPTH_C) begin
            ld_err_d = 1'b1;
          end else begin
            state_d  = ST_LOAD;
            cnt_d    = '0;
            len_d    = eff_len;
            ld_err_d = 1'b0;
`ifdef TINY_PROG_MEM_CSUM_EN
            sum_d    = '0;
`endif
          end
        end
      end

      ST_LOAD: begin
        wdata = ld_data;
        if (ld_valid) begin
`ifdef TINY_PROG_MEM_CSUM_EN
          // Data words first, then one checksum word that is never stored.
          if (cnt_q < len_q) begin
            we    = 1'b1;
            sum_d = sum_q + ld_data;
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            if (DATA_W'(sum_q + ld_data) != '0) ld_err_d = 1'b1;
            state_d = ST_RUN;
            cnt_d   = '0;
          end
`else
          we = 1'b1;
          if (cnt_q == len_q - CNT_W'(1)) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
`endif
        end
      end

      default: state_d = ST_BOOT;
    endcase

    ld_done_d  = (state_q == ST_LOAD) && (state_d == ST_RUN);
    ld_ready_d = (state_d == ST_LOAD);
    busy_d     = (state_d != ST_RUN);
  end

endmodule

// File: tb/tb_tiny_prog_mem.sv
// Self-checking bench for tiny_prog_mem (DEPTH=16): fetch scoreboard plus
// hand sequences for boot, loads, oversize length and reset mid-load.
module tb_tiny_prog_mem;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DEPTH  = 16;
`ifdef TINY_PROG_MEM_CSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              fetch_en;
  logic [ADDR_W-1:0] fetch_addr;
  logic [DATA_W-1:0] fetch_data;
  logic              fetch_valid;
  logic              ld_start;
  logic [ADDR_W:0]   ld_len;
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;
  logic              ld_done;
  logic              ld_err;
  logic              busy;

  tiny_prog_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fetch_en    (fetch_en),
    .fetch_addr  (fetch_addr),
    .fetch_data  (fetch_data),
    .fetch_valid (fetch_valid),
    .ld_start    (ld_start),
    .ld_len      (ld_len),
    .ld_valid    (ld_valid),
    .ld_data     (ld_data),
    .ld_ready    (ld_ready),
    .ld_done     (ld_done),
    .ld_err      (ld_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]       due;
    logic [DATA_W-1:0] data;
  } exp_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] exp;
  } vec_t;

  exp_t              sb[$];
  exp_t              head;
  vec_t              vecs[9];
  logic [DATA_W-1:0] model [DEPTH];
  logic [DATA_W-1:0] words [DEPTH];
  int                tests = 0;
  int                fails = 0;
  logic [31:0]       cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    cyc = cyc + 1;
    #1;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      head = sb.pop_front();
      tests++;
      if (fetch_valid !== 1'b1 || fetch_data !== head.data) begin
        fails++;
        $display("FAIL fetch: got valid=%0b data=%0h, expected valid=1 data=%0h",
                 fetch_valid, fetch_data, head.data);
      end
    end else if (fetch_valid !== 1'b0) begin
      tests++;
      fails++;
      $display("FAIL stray_valid: got fetch_valid=%0b data=%0h at cycle %0d, expected fetch_valid=0",
               fetch_valid, fetch_data, cyc);
    end
  endtask

  task automatic model_boot();
    for (int i = 0; i < int'(DEPTH); i++) model[i] = 8'h00;
    model[0] = 8'h15; model[1] = 8'h21; model[2] = 8'h31;
    model[3] = 8'h53; model[4] = 8'h68; model[5] = 8'h00;
  endtask

  task automatic fetch_exp(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] e);
    fetch_en   = 1'b1;
    fetch_addr = a;
    sb.push_back('{due: cyc + 1, data: e});
    step();
    fetch_en = 1'b0;
  endtask

  task automatic fetch(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] e;
    e = 8'h00;
    if (int'(a) < int'(DEPTH)) e = model[a];
    fetch_exp(a, e);
  endtask

  task automatic boot_wait();
    for (int i = 0; i < int'(DEPTH) - 1; i++) step();
    chk("busy_last_boot", 32'(busy), 32'd1);
    step();
    chk("busy_run", 32'(busy), 32'd0);
  endtask

  // Load n words from 'words'; optionally overlap a fetch with ld_start.
  task automatic do_load(input logic [ADDR_W:0] len, input int n, input bit bad,
                         input bit with_fetch, input bit gaps);
    logic [DATA_W-1:0] sum, cs;
    sum = '0;
    ld_start = 1'b1;
    ld_len   = len;
    if (with_fetch) begin
      fetch_en   = 1'b1;
      fetch_addr = 8'd1;
      sb.push_back('{due: cyc + 1, data: model[1]});
    end
    step();
    ld_start = 1'b0;
    fetch_en = 1'b0;
    chk("busy_load", 32'(busy), 32'd1);
    chk("ld_ready_load", 32'(ld_ready), 32'd1);
    chk("ld_err_clear", 32'(ld_err), 32'd0);
    if (with_fetch) begin
      // Fetch and a second ld_start while loading must both be ignored.
      fetch_en = 1'b1;
      ld_start = 1'b1;
      ld_len   = 9'd1;
      step();
      fetch_en = 1'b0;
      ld_start = 1'b0;
    end
    for (int i = 0; i < n; i++) begin
      ld_valid = 1'b1;
      ld_data  = words[i];
      sum      = sum + words[i];
      model[i] = words[i];
      step();
      ld_valid = 1'b0;
      if (i == 0 && (n > 1 || CSUM)) chk("ld_done_early", 32'(ld_done), 32'd0);
      if (gaps && i < n - 1) begin
        step();
        step();
        chk("ld_ready_gap", 32'(ld_ready), 32'd1);
      end
    end
    if (CSUM) begin
      cs = DATA_W'(8'd0 - sum);
      if (bad) cs = cs + 8'd1;
      ld_valid = 1'b1;
      ld_data  = cs;
      step();
      ld_valid = 1'b0;
    end
    chk("ld_done", 32'(ld_done), 32'd1);
    chk("busy_after_load", 32'(busy), 32'd0);
    chk("ld_ready_after_load", 32'(ld_ready), 32'd0);
    chk("ld_err_after_load", 32'(ld_err), 32'(CSUM && bad));
    step();
    chk("ld_done_pulse", 32'(ld_done), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; fetch_en = 1'b0; fetch_addr = '0; ld_start = 1'b0;
    ld_len = '0; ld_valid = 1'b0; ld_data = '0;
    vecs[0] = '{8'd0,   8'h15};
    vecs[1] = '{8'd1,   8'h21};
    vecs[2] = '{8'd2,   8'h31};
    vecs[3] = '{8'd3,   8'h53};
    vecs[4] = '{8'd4,   8'h68};
    vecs[5] = '{8'd5,   8'h00};
    vecs[6] = '{8'd200, 8'h00};
    vecs[7] = '{8'd15,  8'h00};
    vecs[8] = '{8'd16,  8'h00};
    model_boot();

    step();
    step();
    chk("rst_fetch_data", 32'(fetch_data), 32'd0);
    chk("rst_ld_ready", 32'(ld_ready), 32'd0);
    chk("rst_ld_done", 32'(ld_done), 32'd0);
    chk("rst_ld_err", 32'(ld_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);

    // Boot with a fetch and an ld_start thrown in; neither may take effect.
    rst_n = 1'b1;
    for (int i = 0; i < int'(DEPTH) - 1; i++) begin
      fetch_en = (i == 3);
      ld_start = (i == 5);
      ld_len   = 9'd2;
      step();
    end
    fetch_en = 1'b0;
    ld_start = 1'b0;
    chk("busy_last_boot", 32'(busy), 32'd1);
    step();
    chk("busy_run", 32'(busy), 32'd0);
    chk("ld_ready_run", 32'(ld_ready), 32'd0);

    for (int i = 0; i < 9; i++) fetch_exp(vecs[i].addr, vecs[i].exp);
    step();

    ld_valid = 1'b1;
    ld_data  = 8'hEE;
    step();
    ld_valid = 1'b0;
    fetch(8'd0);

    words[0] = 8'hAA; words[1] = 8'hBB; words[2] = 8'hCC;
    do_load(9'd3, 3, 1'b0, 1'b1, 1'b1);
    for (int a = 0; a < 4; a++) fetch(8'(a));

    for (int i = 0; i < int'(DEPTH); i++) words[i] = 8'(8'h40 + 8'(i * 3));
    do_load(9'd0, int'(DEPTH), 1'b0, 1'b0, 1'b0);
    fetch(8'd0);
    fetch(8'd7);
    fetch(8'd15);

    ld_start = 1'b1;
    ld_len   = 9'd17;
    step();
    ld_start = 1'b0;
    chk("ld_err_oversize", 32'(ld_err), 32'd1);
    chk("busy_oversize", 32'(busy), 32'd0);
    chk("ld_ready_oversize", 32'(ld_ready), 32'd0);
    fetch(8'd2);
    chk("ld_err_sticky", 32'(ld_err), 32'd1);

    words[0] = 8'h01; words[1] = 8'h02;
    do_load(9'd2, 2, 1'b0, 1'b0, 1'b0);
    do_load(9'd2, 2, 1'b1, 1'b0, 1'b0);
    fetch(8'd0);
    fetch(8'd1);
    fetch(8'd2);

    // Reset in the middle of a load must re-run the full boot copy.
    ld_start = 1'b1;
    ld_len   = 9'd4;
    step();
    ld_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ld_valid = 1'b1;
      ld_data  = 8'(8'h11 * (i + 1));
      step();
    end
    ld_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("midload_rst_busy", 32'(busy), 32'd1);
    chk("midload_rst_ready", 32'(ld_ready), 32'd0);
    step();
    step();
    rst_n = 1'b1;
    model_boot();
    boot_wait();
    fetch(8'd0);
    fetch(8'd1);
    fetch(8'd4);
    step();
    step();
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
